udp_port_demux: RTL and testbench
=================================

Name: udp_port_demux

Overview:
- Parametrised successor to the single-port UDP loopback filter.
- Accepts one UDP header per frame and compares its destination port against NUM_PORTS configured ports.
- Steers the following payload frame to the matching output channel, or drops it if nothing matches.
- Sits between the UDP RX stack and per-application RX FIFOs. The routing decision is latched per frame, so it stays stable across payload stalls.

Parameters:
- DATA_WIDTH, 8, payload tdata width in bits.
- NUM_PORTS, 4, number of output channels (1..16).
- PORT_LIST, {16'd1237,16'd1236,16'd1235,16'd1234}, NUM_PORTS*16-bit vector; channel i owns PORT_LIST[16*i+:16] (default: channel 0 = 1234).

Ports:
- clock in 1 system clock
- reset in 1 synchronous, active-high
- s_hdr_valid in 1 UDP header valid
- s_hdr_ready out 1 header accept
- s_hdr_dest_port in 16 UDP destination port
- s_tdata in DATA_WIDTH payload data
- s_tvalid in 1 payload valid
- s_tready out 1 payload ready
- s_tlast in 1 payload end of frame
- s_tuser in 1 payload error flag
- m_tdata out DATA_WIDTH payload data, shared by all channels
- m_tvalid out NUM_PORTS per-channel valid
- m_tready in NUM_PORTS per-channel ready
- m_tlast out 1 shared tlast
- m_tuser out 1 shared tuser
- active_ch out 4 latched channel index (valid while state=FWD)
- busy out 1 state!=IDLE
- drop_count out 32 dropped-frame counter (see Optional Feature)

Behaviour:
- Reset is synchronous, active-high; clock is clock. On reset: state=IDLE, active_ch=0, drop_count=0. Consequently s_hdr_ready=1, s_tready=0, m_tvalid=0, busy=0.
- States: IDLE, FWD, DROP.
- IDLE:
  - s_hdr_ready=1, s_tready=0; payload is stalled until a header is accepted.
  - On s_hdr_valid&&s_hdr_ready, compare dest_port against all PORT_LIST entries in parallel. If several entries match, the lowest index wins.
  - Match: active_ch<=index, go to FWD.
  - No match: go to DROP.
  - Transition takes effect on the next edge, so the first payload beat can transfer one cycle after header accept.
- FWD:
  - s_hdr_ready=0.
  - m_tvalid[active_ch]=s_tvalid; all other m_tvalid bits are 0.
  - s_tready=m_tready[active_ch].
  - m_tdata/m_tlast/m_tuser are combinational pass-through of s_*; this path has zero latency and no register.
  - On a beat where s_tvalid&&s_tready&&s_tlast, return to IDLE.
- DROP:
  - s_hdr_ready=0, s_tready=1, m_tvalid=0.
  - Beats are discarded.
  - On a beat where s_tvalid&&s_tlast, return to IDLE and increment drop_count.
- Back-to-back frames: the header for frame N+1 is accepted in the first IDLE cycle after frame N's tlast beat. Minimum gap is 1 cycle.
- Zero-length frame: not supported; each header must be followed by at least one beat carrying tlast.
- Stalls: in FWD, holding m_tready[active_ch]=0 stalls upstream indefinitely. m_tready of non-selected channels is ignored.
- s_tuser is forwarded unmodified; error frames are not dropped by this block.
- drop_count saturates at 32'hFFFFFFFF and does not wrap.
- Reset mid-frame: immediately IDLE, m_tvalid=0. The upstream stack must be reset in the same cycle; residual beats are not flushed.
- The m_* outputs must meet AXI-stream rules: tvalid must not deassert without a handshake, because s_tvalid obeys the same rule and the selection is frozen for the whole frame.

Optional Feature:
- Macro: UDP_DEMUX_DROP_COUNT_EN.
- Defined: the 32-bit saturating drop_count is implemented as above.
- Undefined: no counter register is implemented, drop_count is tied to 32'd0, and DROP-state behaviour is otherwise identical.

Test Plan:
1. Header port 1234, then 4 beats 0x11..0x14 with tlast on the 4th, m_tready=all 1 -> m_tvalid=4'b0001 for exactly 4 cycles; data 0x11..0x14; m_tlast on 4th beat; busy deasserts the cycle after the last beat.
2. Header port 1236, 3 beats, m_tready[2] toggled 1,0,1,0,1 -> m_tvalid[2] only; s_tready mirrors m_tready[2]; 3 beats delivered in order; other channels never valid.
3. Header port 80, 5 beats with tlast on the 5th -> m_tvalid=0 throughout; s_tready=1; drop_count 0->1 (0 without the macro); back in IDLE after the 5th beat.
4. Frames to 1235 then 1234 back-to-back, second header asserted during the first frame -> s_hdr_ready=0 until the first tlast; second header accepted 1 cycle later; active_ch goes 1 then 0.
5. PORT_LIST with duplicate 1234 at index 0 and 3, header 1234 -> routed to channel 0.
6. Reset asserted on the 2nd beat of a 4-beat FWD frame -> next cycle: m_tvalid=0, s_hdr_ready=1, busy=0, drop_count=0.

Source files
------------

// File: rtl/udp_port_demux_if.sv
// ---------------------------------------------------------------------------
// udp_port_demux_if
// Bundles the UDP header handshake, the upstream payload stream and the
// fanned-out downstream payload streams of udp_port_demux.
//
// Signals:
//   s_hdr_valid / s_hdr_ready / s_hdr_dest_port : one UDP header per frame
//   s_tdata / s_tvalid / s_tready / s_tlast / s_tuser : upstream payload
//   m_tdata / m_tlast / m_tuser : downstream payload, shared by all channels
//   m_tvalid / m_tready          : per-channel handshake (NUM_PORTS bits)
//
// Modports:
//   slave  : the demux itself (consumes header + payload, drives channels)
//   master : the surrounding environment (UDP RX stack + application FIFOs)
// ---------------------------------------------------------------------------
interface udp_port_demux_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PORTS  = 4
);
   logic                  s_hdr_valid;
   logic                  s_hdr_ready;
   logic [15:0]           s_hdr_dest_port;
   logic [DATA_WIDTH-1:0] s_tdata;
   logic                  s_tvalid;
   logic                  s_tready;
   logic                  s_tlast;
   logic                  s_tuser;
   logic [DATA_WIDTH-1:0] m_tdata;
   logic [NUM_PORTS-1:0]  m_tvalid;
   logic [NUM_PORTS-1:0]  m_tready;
   logic                  m_tlast;
   logic                  m_tuser;

   modport slave (
      input  s_hdr_valid, s_hdr_dest_port,
      input  s_tdata, s_tvalid, s_tlast, s_tuser,
      input  m_tready,
      output s_hdr_ready, s_tready,
      output m_tdata, m_tvalid, m_tlast, m_tuser
   );

   modport master (
      output s_hdr_valid, s_hdr_dest_port,
      output s_tdata, s_tvalid, s_tlast, s_tuser,
      output m_tready,
      input  s_hdr_ready, s_tready,
      input  m_tdata, m_tvalid, m_tlast, m_tuser
   );
endinterface

// File: rtl/udp_port_demux.sv
// ---------------------------------------------------------------------------
// udp_port_demux
// Accepts one UDP header per frame, matches its destination port against
// NUM_PORTS configured ports (lowest index wins on duplicates) and steers the
// following payload frame to the matching channel, or silently drops it.
// The routing decision is latched per frame, so it stays stable across
// payload stalls. The payload path itself is a zero-latency pass-through.
//
// Parameters:
//   DATA_WIDTH : payload width
//   NUM_PORTS  : number of output channels (1..16)
//   PORT_LIST  : NUM_PORTS*16 bits, channel i owns PORT_LIST[16*i +: 16]
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : udp_port_demux_if.slave (header, payload in, channels out)
//   active_ch    : latched channel index, meaningful while forwarding
//   busy         : high whenever a frame is in progress (not IDLE)
//   drop_count   : saturating count of dropped frames
//
// Build option:
//   UDP_DEMUX_DROP_COUNT_EN : when defined, drop_count is a 32-bit saturating
//                             counter; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module udp_port_demux #(
   parameter int                        DATA_WIDTH = 8,
   parameter int                        NUM_PORTS  = 4,
   parameter logic [NUM_PORTS*16-1:0]   PORT_LIST  = {16'd1237, 16'd1236, 16'd1235, 16'd1234}
) (
   input  logic                 clock,
   input  logic                 reset,
   udp_port_demux_if.slave      bus,
   output logic [3:0]           active_ch,
   output logic                 busy,
   output logic [31:0]          drop_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t               state_reg;
   logic [3:0]           active_ch_reg;

   logic [NUM_PORTS-1:0] port_match;
   logic                 hit_any;
   logic [3:0]           hit_idx;
   logic [NUM_PORTS-1:0] ch_onehot;
   logic                 sel_ready;

   // Parallel compare of the header port against every configured port.
   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_match
         assign port_match[gi] = (bus.s_hdr_dest_port == PORT_LIST[16*gi +: 16]);
         assign ch_onehot[gi]  = (active_ch_reg == 4'(gi));
         assign bus.m_tvalid[gi] = (state_reg == FWD) && ch_onehot[gi] && bus.s_tvalid;
      end
   endgenerate

   // Priority encoder: scan from the top so the lowest matching index is the
   // last one written and therefore wins.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = 4'd0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_match[i]) begin
            hit_any = 1'b1;
            hit_idx = 4'(i);
         end
      end
   end

   // Ready of the latched channel only; the others are ignored.
   assign sel_ready = |(bus.m_tready & ch_onehot);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         active_ch_reg <= 4'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.s_hdr_valid) begin
                  if (hit_any) begin
                     active_ch_reg <= hit_idx;
                     state_reg     <= FWD;
                  end else begin
                     state_reg     <= DROP;
                  end
               end
            end
            FWD: begin
               if (bus.s_tvalid && sel_ready && bus.s_tlast)
                  state_reg <= IDLE;
            end
            DROP: begin
               // s_tready is constantly high here, so valid+last is the beat.
               if (bus.s_tvalid && bus.s_tlast)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef UDP_DEMUX_DROP_COUNT_EN
   logic [31:0] drop_count_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         drop_count_reg <= 32'd0;
      end else if ((state_reg == DROP) && bus.s_tvalid && bus.s_tlast &&
                   (drop_count_reg != 32'hFFFF_FFFF)) begin
         drop_count_reg <= drop_count_reg + 32'd1;
      end
   end

   assign drop_count = drop_count_reg;
`else
   assign drop_count = 32'd0;
`endif

   // Header is only taken between frames; payload is stalled in IDLE.
   assign bus.s_hdr_ready = (state_reg == IDLE);
   assign bus.s_tready    = (state_reg == FWD)  ? sel_ready :
                            (state_reg == DROP);

   // Shared pass-through; only the per-channel valid qualifies it.
   assign bus.m_tdata = bus.s_tdata;
   assign bus.m_tlast = bus.s_tlast;
   assign bus.m_tuser = bus.s_tuser;

   assign active_ch = active_ch_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_udp_port_demux.sv
// ---------------------------------------------------------------------------
// tb_udp_port_demux
// Self-checking bench for udp_port_demux. Expected output beats are pushed to
// a scoreboard queue when driven and compared when a channel handshake is
// seen. A second instance with a duplicated port list shares the stimulus.
// ---------------------------------------------------------------------------
module tb_udp_port_demux;

   localparam int DW = 8;
   localparam int NP = 4;

   typedef struct {
      int         ch;
      logic [7:0] data;
      logic       last;
      logic       user;
   } beat_t;

   logic        clock;
   logic        reset;
   logic [3:0]  active_ch, active_ch_dup;
   logic        busy, busy_dup;
   logic [31:0] drop_count, drop_count_dup;

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   int    exp_drop = 0;
   beat_t sb[$];
   logic [NP-1:0] seen_mask;
   logic [NP-1:0] dup_seen_mask;
   int    ch0_valid_cycles;

   udp_port_demux_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();
   udp_port_demux_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus_dup ();

   udp_port_demux #(
      .DATA_WIDTH(DW), .NUM_PORTS(NP),
      .PORT_LIST({16'd1237, 16'd1236, 16'd1235, 16'd1234})
   ) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .active_ch(active_ch), .busy(busy), .drop_count(drop_count)
   );

   // Port 1234 at both index 0 and index 3.
   udp_port_demux #(
      .DATA_WIDTH(DW), .NUM_PORTS(NP),
      .PORT_LIST({16'd1234, 16'd1236, 16'd1235, 16'd1234})
   ) dut_dup (
      .clock(clock), .reset(reset), .bus(bus_dup),
      .active_ch(active_ch_dup), .busy(busy_dup), .drop_count(drop_count_dup)
   );

   assign bus_dup.s_hdr_valid     = bus.s_hdr_valid;
   assign bus_dup.s_hdr_dest_port = bus.s_hdr_dest_port;
   assign bus_dup.s_tdata         = bus.s_tdata;
   assign bus_dup.s_tvalid        = bus.s_tvalid;
   assign bus_dup.s_tlast         = bus.s_tlast;
   assign bus_dup.s_tuser         = bus.s_tuser;
   assign bus_dup.m_tready        = bus.m_tready;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
      end
   endtask

   // Output monitor, sampled mid-cycle so the combinational outputs are stable.
   always @(negedge clock) begin
      if (!reset) begin
         seen_mask     = seen_mask | bus.m_tvalid;
         dup_seen_mask = dup_seen_mask | bus_dup.m_tvalid;
         if (bus.m_tvalid == 4'b0001) ch0_valid_cycles++;
         if ($countones(bus.m_tvalid) > 1)
            check("m_tvalid_onehot", 32'($countones(bus.m_tvalid)), 32'd1);
         if ((bus.m_tvalid & bus.m_tready) != '0) begin
            int ch;
            beat_t e;
            ch = 0;
            for (int i = 0; i < NP; i++) if (bus.m_tvalid[i]) ch = i;
            if (sb.size() == 0) begin
               check("unexpected_beat", 32'(ch), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check("beat_ch",   32'(ch), 32'(e.ch));
               check("beat_data", 32'(bus.m_tdata), 32'(e.data));
               check("beat_last", 32'(bus.m_tlast), 32'(e.last));
               check("beat_user", 32'(bus.m_tuser), 32'(e.user));
               $display("beat ch=%0d data=%02h last=%0b user=%0b", ch, bus.m_tdata, bus.m_tlast, bus.m_tuser);
            end
         end
      end
   end

   task automatic send_header(input logic [15:0] port, output int acc_cyc);
      int n;
      n = 0;
      acc_cyc = -1;
      bus.s_hdr_valid     = 1'b1;
      bus.s_hdr_dest_port = port;
      while (1) begin
         @(negedge clock);
         if (bus.s_hdr_ready) begin
            acc_cyc = cyc;
            break;
         end
         n++;
         if (n > 200) begin
            check("hdr_timeout", 32'd1, 32'd0);
            break;
         end
      end
      @(posedge clock);
      #1;
      bus.s_hdr_valid = 1'b0;
      $display("header port=%0d accepted at cycle %0d", port, acc_cyc);
   endtask

   // ch < 0 means the frame is expected to be dropped.
   task automatic send_beats(input int n, input logic [7:0] base, input int ch,
                             input logic [15:0] rdy_pat, output int last_cyc);
      int pc;
      pc = 0;
      last_cyc = -1;
      for (int b = 0; b < n; b++) begin
         logic hs;
         int   k;
         beat_t e;
         bus.s_tvalid = 1'b1;
         bus.s_tdata  = base + 8'(b);
         bus.s_tlast  = (b == n - 1);
         bus.s_tuser  = (b == 1);
         if (ch >= 0) begin
            e.ch = ch; e.data = base + 8'(b); e.last = (b == n - 1); e.user = (b == 1);
            sb.push_back(e);
         end
         k = 0;
         while (1) begin
            bus.m_tready = rdy_pat[pc % 16] ? 4'hF : 4'hB;
            @(negedge clock);
            if (ch >= 0) check("s_tready_mirror", 32'(bus.s_tready), 32'(bus.m_tready[ch]));
            else         check("drop_tready",     32'(bus.s_tready), 32'd1);
            hs = bus.s_tready;
            if (hs && (b == n - 1)) last_cyc = cyc;
            @(posedge clock);
            #1;
            pc++;
            if (hs) break;
            k++;
            if (k > 200) begin
               check("beat_timeout", 32'd1, 32'd0);
               break;
            end
         end
      end
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
      bus.s_tuser  = 1'b0;
      bus.m_tready = 4'hF;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_a, acc_b, last_a, dummy;
      reset = 1'b1;
      bus.s_hdr_valid = 1'b0; bus.s_hdr_dest_port = 16'd0;
      bus.s_tdata = '0; bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0; bus.s_tuser = 1'b0;
      bus.m_tready = 4'hF;
      seen_mask = '0; dup_seen_mask = '0; ch0_valid_cycles = 0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state
      @(negedge clock);
      check("rst_hdr_ready", 32'(bus.s_hdr_ready), 32'd1);
      check("rst_tready",    32'(bus.s_tready), 32'd0);
      check("rst_tvalid",    32'(bus.m_tvalid), 32'd0);
      check("rst_busy",      32'(busy), 32'd0);
      check("rst_active_ch", 32'(active_ch), 32'd0);
      check("rst_drop",      drop_count, 32'd0);
      @(posedge clock); #1;

      // 1: port 1234 -> channel 0, four beats at full rate
      seen_mask = '0; ch0_valid_cycles = 0;
      send_header(16'd1234, acc_a);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_active_ch", 32'(active_ch), 32'd0);
      send_beats(4, 8'h11, 0, 16'hFFFF, last_a);
      check("t1_busy_after", 32'(busy), 32'd0);
      check("t1_valid_cycles", 32'(ch0_valid_cycles), 32'd4);
      check("t1_seen", 32'(seen_mask), 32'b0001);

      // 2: port 1236 -> channel 2 with ready toggling 1,0,1,0,1
      seen_mask = '0;
      send_header(16'd1236, acc_a);
      check("t2_active_ch", 32'(active_ch), 32'd2);
      send_beats(3, 8'h21, 2, 16'h5555, last_a);
      check("t2_seen", 32'(seen_mask), 32'b0100);
      check("t2_busy_after", 32'(busy), 32'd0);

      // 3: port 80 -> dropped
      seen_mask = '0;
      check("t3_drop_before", drop_count, 32'(exp_drop));
      send_header(16'd80, acc_a);
      check("t3_busy", 32'(busy), 32'd1);
      send_beats(5, 8'h31, -1, 16'hFFFF, last_a);
`ifdef UDP_DEMUX_DROP_COUNT_EN
      exp_drop++;
`endif
      check("t3_drop_after", drop_count, 32'(exp_drop));
      check("t3_seen", 32'(seen_mask), 32'd0);
      check("t3_idle", 32'(bus.s_hdr_ready), 32'd1);

      // 4: back-to-back, second header pending during the first frame
      send_header(16'd1235, acc_a);
      check("t4_active_ch_a", 32'(active_ch), 32'd1);
      fork
         send_beats(3, 8'h41, 1, 16'hFFFF, last_a);
         send_header(16'd1234, acc_b);
      join
      check("t4_hdr_gap", 32'(acc_b - last_a), 32'd1);
      check("t4_active_ch_b", 32'(active_ch), 32'd0);
      send_beats(2, 8'h51, 0, 16'hFFFF, dummy);

      // 5: duplicated port list, lowest index wins
      dup_seen_mask = '0;
      send_header(16'd1234, acc_a);
      check("t5_dup_active_ch", 32'(active_ch_dup), 32'd0);
      send_beats(2, 8'h55, 0, 16'hFFFF, dummy);
      check("t5_dup_seen", 32'(dup_seen_mask), 32'b0001);

      // 6: reset on the second beat of a forwarded frame
      send_header(16'd1234, acc_a);
      begin
         beat_t e;
         bus.s_tvalid = 1'b1; bus.s_tdata = 8'h61; bus.s_tlast = 1'b0; bus.s_tuser = 1'b0;
         e.ch = 0; e.data = 8'h61; e.last = 1'b0; e.user = 1'b0;
         sb.push_back(e);
         bus.m_tready = 4'hF;
         @(posedge clock); #1;
         bus.s_tdata = 8'h62; bus.m_tready = 4'h0; reset = 1'b1;
         @(posedge clock); #1;
         reset = 1'b0; bus.m_tready = 4'hF;
         exp_drop = 0;
         check("t6_tvalid",    32'(bus.m_tvalid), 32'd0);
         check("t6_hdr_ready", 32'(bus.s_hdr_ready), 32'd1);
         check("t6_busy",      32'(busy), 32'd0);
         check("t6_drop",      drop_count, 32'(exp_drop));
         check("t6_tready",    32'(bus.s_tready), 32'd0);
         bus.s_tvalid = 1'b0;
      end

      // Recovery after reset: port 1237 -> channel 3
      seen_mask = '0;
      send_header(16'd1237, acc_a);
      check("t7_active_ch", 32'(active_ch), 32'd3);
      send_beats(2, 8'h71, 3, 16'hFFFF, dummy);
      check("t7_seen", 32'(seen_mask), 32'b1000);

      repeat (2) @(posedge clock);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
